cache_assoc_wb: RTL and testbench
=================================

Name: cache_assoc_wb

Overview:
- Parametrised, clocked successor to the direct-mapped `cache`.
- 1- or 2-way set-associative, write-back, write-allocate data cache with one-word lines.
- Sits between the CPU load/store path and a backing memory. The CPU side keeps `memRead`/`memWrite`/`address`/`value`; a req/ack handshake to memory is added, and hit/miss counters replace the LED outputs.

Parameters:
- ADDR_W, 32, address width in bits; address[1:0] is the byte offset and is ignored.
- DATA_W, 32, data word width.
- INDEX_W, 3, set index width; set count is 2**INDEX_W (default 8 sets, index = address[4:2]).
- WAYS, 2, associativity; legal values are 1 and 2. Elaboration fails on any other value.
- CNT_W, 16, width of the hit/miss counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- memRead  in  1  CPU read request, sampled in IDLE.
- memWrite  in  1  CPU write request, sampled in IDLE; wins over memRead if both are high.
- address  in  ADDR_W  CPU byte address.
- value  in  DATA_W  CPU write data.
- ready  out  1  high in IDLE; a request is accepted only when ready=1.
- done  out  1  one-cycle pulse when a request completes.
- out  out  DATA_W  read data (or the written word, for a write); holds until the next done.
- hit  out  1  hit flag for the completed request; holds until the next done.
- memReq  out  1  backing-memory request.
- memWe  out  1  1 = write-back, 0 = fill read.
- memAddr  out  ADDR_W  word-aligned memory address; bits [1:0] = 0.
- memWData  out  DATA_W  write-back data.
- memAck  in  1  memory completes the current transfer in this cycle.
- memRData  in  DATA_W  fill data, valid while memAck=1.
- hitCount  out  CNT_W  saturating count of hits.
- missCount  out  CNT_W  saturating count of misses.

Behaviour:
- Address split:
  - tag = address[ADDR_W-1 : INDEX_W+2]
  - index = address[INDEX_W+1 : 2]
- Per-line state: valid, dirty, tag, data.
- Per-set state: lru bit, meaning "way to evict next". Unused when WAYS=1.
- Reset, asynchronous:
  - All valid, dirty and lru bits cleared.
  - State goes to IDLE.
  - Outputs: ready=1, done=0, out=0, hit=0, memReq=0, memWe=0, memAddr=0, memWData=0, counters=0.
  - Reset during WRITEBACK or FILL aborts the transfer; memReq drops immediately. Any memAck after that is ignored.
- IDLE:
  - Accepts a request if memRead|memWrite.
  - Latches the operation, address and value; CPU inputs are ignored until the next IDLE.
  - The tag compare is combinational against all ways of the indexed set.
- Hit (completes on the accept edge, 1-cycle latency, stays in IDLE):
  - Read: out <= line data.
  - Write: line data <= value, dirty <= 1, out <= value.
  - hit <= 1, done pulses next cycle, hitCount increments.
  - lru <= ~hit_way.
- Miss:
  - missCount increments.
  - Victim choice: the first invalid way (way0 preferred), else the lru way. WAYS=1 always uses way0.
  - If the victim is valid and dirty, go to WRITEBACK; otherwise go to FILL.
- WRITEBACK:
  - memReq=1, memWe=1, memAddr={victim tag, index, 2'b00}, memWData=victim data.
  - Held stable until memAck.
  - On memAck: clear the victim's dirty bit, go to FILL.
- FILL:
  - memReq=1, memWe=0, memAddr={req tag, index, 2'b00}.
  - On memAck: install the line (valid=1, tag=req tag).
    - Read: data=memRData, dirty=0, out=memRData.
    - Write: data=value, dirty=1, out=value.
  - hit <= 0, lru <= ~victim_way, done pulses next cycle, return to IDLE.
  - memReq deasserts in the cycle after memAck.
- Latency:
  - Hit: 1 cycle.
  - Clean miss: 1 + fill wait + 1.
  - Dirty miss: adds write-back wait.
- memAck while memReq=0 is ignored.
- Counters saturate at all-ones.
- A new request may be presented in the same cycle done is high; ready is already 1 at that point.

Decomposition:
- Package cache_pkg:
  - state enum: IDLE, WRITEBACK, FILL.
  - OFFSET_W=2.
  - Helper functions for tag and index extraction, parameterised by ADDR_W and INDEX_W.
- Sub-module cache_way_array:
  - One instance per way.
  - Holds valid/dirty/tag/data storage for 2**INDEX_W sets.
  - Asynchronous read by index, synchronous write port, asynchronous clear on rst_n.
- The top level keeps the FSM, LRU bits, victim select and counters.

Test Plan:
1. Reset, then read 0x00000014 (set 5), memory returns 0xA5A5A5A5 after 3 cycles.
   -> memReq with memWe=0, memAddr=0x14; then done, hit=0, out=0xA5A5A5A5, missCount=1.
2. Read 0xFFFFFC14 (same set, different tag).
   -> fills way1, no write-back, hit=0. Re-reading 0x14 gives hit=1 in 1 cycle, out=0xA5A5A5A5, hitCount=1.
3. Write 99 to 0xFFFFFC1C (miss), then read 0xFFFFFC1C.
   -> the write ends with hit=0, out=99; the read gives hit=1, out=99, one cycle after accept.
4. In set 7, access a second tag and then a third tag 0x0000001C.
   -> WRITEBACK first with memWe=1, memAddr=0xFFFFFC1C, memWData=99; then FILL with memAddr=0x1C.
5. WAYS=1 build: read 0x14 then 0xFFFFFC14.
   -> the second access evicts the first with no write-back (line clean). Re-reading 0x14 misses again.
6. Assert rst_n low during FILL while memAck is held low.
   -> memReq=0 immediately; ready=1, counters=0, all lines invalid. A subsequent read of 0x14 misses.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and address helpers for the set-associative write-back cache.
// Exports the FSM state enum, the byte-offset width and tag/index extractors.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FILL
    } state_t;

    localparam int OFFSET_W = 2;

    // Callers zero-extend the address to 64 bits and truncate the result.
    function automatic logic [63:0] addr_tag(input logic [63:0] addr,
                                             input int          index_w);
        return addr >> (index_w + OFFSET_W);
    endfunction

    function automatic logic [63:0] addr_index(input logic [63:0] addr,
                                               input int          index_w);
        return (addr >> OFFSET_W) & ((64'd1 << index_w) - 64'd1);
    endfunction

endpackage

// File: rtl/cache_way_array.sv
// One way of the cache: valid/dirty/tag/data storage for 2**INDEX_W sets.
// Ports: rd_idx_i -> valid_o/dirty_o/tag_o/data_o (async); we_i/wr_* (sync).
module cache_way_array
    import cache_pkg::*;
#(
    parameter int INDEX_W = 3,
    parameter int TAG_W   = 27,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] rd_idx_i,
    output logic               valid_o,
    output logic               dirty_o,
    output logic [TAG_W-1:0]   tag_o,
    output logic [DATA_W-1:0]  data_o,
    input  logic               we_i,
    input  logic [INDEX_W-1:0] wr_idx_i,
    input  logic               wr_valid_i,
    input  logic               wr_dirty_i,
    input  logic [TAG_W-1:0]   wr_tag_i,
    input  logic [DATA_W-1:0]  wr_data_i
);

    localparam int SETS = 2 ** INDEX_W;

    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   dirty_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [DATA_W-1:0] data_q [SETS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (we_i) begin
            valid_q[wr_idx_i] <= wr_valid_i;
            dirty_q[wr_idx_i] <= wr_dirty_i;
        end
    end

    // Tag/data are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign valid_o = valid_q[rd_idx_i];
    assign dirty_o = dirty_q[rd_idx_i];
    assign tag_o   = tag_q[rd_idx_i];
    assign data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/cache_assoc_wb.sv
// 1/2-way set-associative write-back, write-allocate cache, one-word lines.
// CPU: memRead/memWrite/address/value -> ready/done/out/hit; memory: req/ack.
module cache_assoc_wb
    import cache_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int INDEX_W = 3,
    parameter int WAYS    = 2,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] value,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] out,
    output logic              hit,
    output logic              memReq,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWData,
    input  logic              memAck,
    input  logic [DATA_W-1:0] memRData,
    output logic [CNT_W-1:0]  hitCount,
    output logic [CNT_W-1:0]  missCount
);

    localparam int SETS  = 2 ** INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

    if (WAYS != 1 && WAYS != 2) begin : g_bad_ways
        $error("cache_assoc_wb: WAYS must be 1 or 2");
    end

    state_t            state_q, state_d;
    logic              wr_op_q, wr_op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              victim_q, victim_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              hit_q, hit_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  hcnt_q, hcnt_d;
    logic [CNT_W-1:0]  mcnt_q, mcnt_d;
    logic [SETS-1:0]   lru_q, lru_d;

    logic [INDEX_W-1:0] in_idx, q_idx, rd_idx;
    logic [TAG_W-1:0]   in_tag, q_tag;

    assign in_idx = INDEX_W'(addr_index(64'(address), INDEX_W));
    assign in_tag = TAG_W'(addr_tag(64'(address), INDEX_W));
    assign q_idx  = INDEX_W'(addr_index(64'(addr_q), INDEX_W));
    assign q_tag  = TAG_W'(addr_tag(64'(addr_q), INDEX_W));
    // Look up the live request in IDLE, the latched one during transfers.
    assign rd_idx = (state_q == IDLE) ? in_idx : q_idx;

    logic [WAYS-1:0]    rv, rdirty, we;
    logic [TAG_W-1:0]   rtag  [WAYS];
    logic [DATA_W-1:0]  rdata [WAYS];
    logic               wr_valid, wr_dirty;
    logic [TAG_W-1:0]   wr_tag;
    logic [DATA_W-1:0]  wr_data;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        cache_way_array #(
            .INDEX_W(INDEX_W),
            .TAG_W  (TAG_W),
            .DATA_W (DATA_W)
        ) u_way (
            .clk       (clk),
            .rst_n     (rst_n),
            .rd_idx_i  (rd_idx),
            .valid_o   (rv[w]),
            .dirty_o   (rdirty[w]),
            .tag_o     (rtag[w]),
            .data_o    (rdata[w]),
            .we_i      (we[w]),
            .wr_idx_i  (rd_idx),
            .wr_valid_i(wr_valid),
            .wr_dirty_i(wr_dirty),
            .wr_tag_i  (wr_tag),
            .wr_data_i (wr_data)
        );
    end

    logic [WAYS-1:0]   hv;
    logic              any_hit, hit_way;
    logic [DATA_W-1:0] hit_data;
    logic              pick, pick_vd;
    logic [TAG_W-1:0]  vic_tag;
    logic [DATA_W-1:0] vic_data;

    always_comb begin
        hv       = '0;
        hit_way  = 1'b0;
        hit_data = '0;
        pick     = (WAYS == 2) ? lru_q[in_idx] : 1'b0;
        pick_vd  = 1'b0;
        vic_tag  = '0;
        vic_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            hv[w] = rv[w] && (rtag[w] == in_tag);
            if (hv[w]) begin
                hit_way  = 1'(w);
                hit_data = rdata[w];
            end
        end
        // Descending scan so the lowest invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!rv[w]) pick = 1'(w);
        end
        for (int w = 0; w < WAYS; w++) begin
            if (1'(w) == pick) pick_vd = rv[w] && rdirty[w];
            if (1'(w) == victim_q) begin
                vic_tag  = rtag[w];
                vic_data = rdata[w];
            end
        end
    end
    assign any_hit = |hv;

    always_comb begin
        state_d  = state_q;
        wr_op_d  = wr_op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        victim_d = victim_q;
        out_d    = out_q;
        hit_d    = hit_q;
        done_d   = 1'b0;
        hcnt_d   = hcnt_q;
        mcnt_d   = mcnt_q;
        lru_d    = lru_q;
        we       = '0;
        wr_valid = 1'b0;
        wr_dirty = 1'b0;
        wr_tag   = '0;
        wr_data  = '0;
        memReq   = 1'b0;
        memWe    = 1'b0;
        memAddr  = '0;
        memWData = '0;
        unique case (state_q)
            IDLE: begin
                if (memRead || memWrite) begin
                    wr_op_d = memWrite;
                    addr_d  = address;
                    wdata_d = value;
                    if (any_hit) begin
                        hit_d         = 1'b1;
                        done_d        = 1'b1;
                        lru_d[in_idx] = ~hit_way;
                        if (!(&hcnt_q)) hcnt_d = hcnt_q + CNT_W'(1);
                        if (memWrite) begin
                            we       = hv;
                            wr_valid = 1'b1;
                            wr_dirty = 1'b1;
                            wr_tag   = in_tag;
                            wr_data  = value;
                            out_d    = value;
                        end else begin
                            out_d = hit_data;
                        end
                    end else begin
                        if (!(&mcnt_q)) mcnt_d = mcnt_q + CNT_W'(1);
                        victim_d = pick;
                        state_d  = pick_vd ? WRITEBACK : FILL;
                    end
                end
            end
            WRITEBACK: begin
                memReq   = 1'b1;
                memWe    = 1'b1;
                memAddr  = {vic_tag, q_idx, 2'b00};
                memWData = vic_data;
                if (memAck) begin
                    for (int w = 0; w < WAYS; w++)
                        we[w] = (1'(w) == victim_q);
                    wr_valid = 1'b1;
                    wr_dirty = 1'b0;
                    wr_tag   = vic_tag;
                    wr_data  = vic_data;
                    state_d  = FILL;
                end
            end
            FILL: begin
                memReq  = 1'b1;
                memAddr = {q_tag, q_idx, 2'b00};
                if (memAck) begin
                    for (int w = 0; w < WAYS; w++)
                        we[w] = (1'(w) == victim_q);
                    wr_valid     = 1'b1;
                    wr_dirty     = wr_op_q;
                    wr_tag       = q_tag;
                    wr_data      = wr_op_q ? wdata_q : memRData;
                    out_d        = wr_data;
                    hit_d        = 1'b0;
                    done_d       = 1'b1;
                    lru_d[q_idx] = ~victim_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_op_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            victim_q <= 1'b0;
            out_q    <= '0;
            hit_q    <= 1'b0;
            done_q   <= 1'b0;
            hcnt_q   <= '0;
            mcnt_q   <= '0;
            lru_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_op_q  <= wr_op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            victim_q <= victim_d;
            out_q    <= out_d;
            hit_q    <= hit_d;
            done_q   <= done_d;
            hcnt_q   <= hcnt_d;
            mcnt_q   <= mcnt_d;
            lru_q    <= lru_d;
        end
    end

    assign ready     = (state_q == IDLE);
    assign done      = done_q;
    assign out       = out_q;
    assign hit       = hit_q;
    assign hitCount  = hcnt_q;
    assign missCount = mcnt_q;

endmodule

// File: tb/tb_cache_assoc_wb.sv
// Directed bench for cache_assoc_wb: a 2-way and a 1-way instance,
// a behavioural backing memory and a scoreboard of expected completions.
module tb_cache_assoc_wb;

    localparam int W = 3;

    logic        clk;
    logic        rst_n;
    logic        rd   [2];
    logic        wr   [2];
    logic [31:0] ad   [2];
    logic [31:0] vl   [2];
    logic        rdy  [2];
    logic        dn   [2];
    logic [31:0] ot   [2];
    logic        ht   [2];
    logic        mrq  [2];
    logic        mwe  [2];
    logic [31:0] mad  [2];
    logic [31:0] mwd  [2];
    logic        mack [2];
    logic [31:0] mrd  [2];
    logic [15:0] hcnt [2];
    logic [15:0] mcnt [2];

    int checks   = 0;
    int failures = 0;
    int hc_m [2];
    int mc_m [2];

    typedef struct {
        logic [31:0] out;
        logic        hit;
        int          cyc;
        int          hc;
        int          mc;
    } exp_t;

    exp_t sbq [$];

    logic [31:0] bmem    [logic [31:0]];
    logic [31:0] cpu_mem [logic [31:0]];

    cache_assoc_wb #(.WAYS(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .memRead(rd[0]), .memWrite(wr[0]),
        .address(ad[0]), .value(vl[0]),
        .ready(rdy[0]), .done(dn[0]), .out(ot[0]), .hit(ht[0]),
        .memReq(mrq[0]), .memWe(mwe[0]),
        .memAddr(mad[0]), .memWData(mwd[0]),
        .memAck(mack[0]), .memRData(mrd[0]),
        .hitCount(hcnt[0]), .missCount(mcnt[0])
    );

    cache_assoc_wb #(.WAYS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .memRead(rd[1]), .memWrite(wr[1]),
        .address(ad[1]), .value(vl[1]),
        .ready(rdy[1]), .done(dn[1]), .out(ot[1]), .hit(ht[1]),
        .memReq(mrq[1]), .memWe(mwe[1]),
        .memAddr(mad[1]), .memWData(mwd[1]),
        .memAck(mack[1]), .memRData(mrd[1]),
        .hitCount(hcnt[1]), .missCount(mcnt[1])
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a == 32'h14) ? 32'hA5A5_A5A5 : (a ^ 32'h5A5A_0000);
    endfunction

    function automatic logic [31:0] bmem_rd(input logic [31:0] a);
        return bmem.exists(a) ? bmem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] cpu_rd(input logic [31:0] a);
        return cpu_mem.exists(a) ? cpu_mem[a] : init_val(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic access(input int d, input bit w,
                          input logic [31:0] a, input logic [31:0] v,
                          input bit eh, input bit ewb,
                          input logic [31:0] wba, input logic [31:0] wbd);
        exp_t e;
        int   cyc;
        int   rc;
        bit   fin;
        bit   wbseen;
        @(negedge clk);
        chk("ready", 32'(rdy[d]), 1);
        rd[d] = !w;
        wr[d] = w;
        ad[d] = a;
        vl[d] = v;
        if (eh) hc_m[d]++;
        else mc_m[d]++;
        if (w) cpu_mem[a] = v;
        e.out = cpu_rd(a);
        e.hit = eh;
        e.cyc = eh ? 1 : (ewb ? 2 * W + 1 : W + 1);
        e.hc  = hc_m[d];
        e.mc  = mc_m[d];
        sbq.push_back(e);
        @(posedge clk);
        #1;
        rd[d] = 1'b0;
        wr[d] = 1'b0;
        cyc = 0;
        rc = 0;
        fin = 0;
        wbseen = 0;
        for (int i = 0; i < 60 && !fin; i++) begin
            @(negedge clk);
            cyc++;
            mack[d] = 1'b0;
            if (dn[d]) begin
                e = sbq.pop_front();
                chk("out", ot[d], e.out);
                chk("hit", 32'(ht[d]), 32'(e.hit));
                chk("latency", cyc, e.cyc);
                chk("hitCount", 32'(hcnt[d]), e.hc);
                chk("missCount", 32'(mcnt[d]), e.mc);
                chk("memReq_off", 32'(mrq[d]), 0);
                chk("wb_seen", 32'(wbseen), 32'(ewb));
                fin = 1;
            end else if (mrq[d]) begin
                rc++;
                if (rc == 1) begin
                    if (mwe[d]) begin
                        wbseen = 1;
                        chk("wb_addr", mad[d], wba);
                        chk("wb_data", mwd[d], wbd);
                    end else begin
                        chk("fill_addr", mad[d], a & 32'hFFFF_FFFC);
                    end
                end
                if (rc == W) begin
                    if (mwe[d]) bmem[mad[d]] = mwd[d];
                    else mrd[d] = bmem_rd(mad[d]);
                    mack[d] = 1'b1;
                    rc = 0;
                end
            end
        end
        chk("done_seen", 32'(fin), 1);
        if (!fin && sbq.size() > 0) void'(sbq.pop_front());
    endtask

    initial begin
        bit seen;
        clk = 0;
        rst_n = 0;
        for (int d = 0; d < 2; d++) begin
            rd[d] = 0; wr[d] = 0; ad[d] = 0; vl[d] = 0;
            mack[d] = 0; mrd[d] = 0;
            hc_m[d] = 0; mc_m[d] = 0;
        end
        #12;
        chk("rst_ready", 32'(rdy[0]), 1);
        chk("rst_done", 32'(dn[0]), 0);
        chk("rst_out", ot[0], 0);
        chk("rst_hit", 32'(ht[0]), 0);
        chk("rst_memReq", 32'(mrq[0]), 0);
        chk("rst_memWe", 32'(mwe[0]), 0);
        chk("rst_memAddr", mad[0], 0);
        chk("rst_memWData", mwd[0], 0);
        chk("rst_hitCount", 32'(hcnt[0]), 0);
        chk("rst_missCount", 32'(mcnt[0]), 0);
        chk("rst_ready1", 32'(rdy[1]), 1);
        @(negedge clk);
        rst_n = 1;

        // set 5: clean fills into way0 then way1, then a hit on way0
        access(0, 0, 32'h0000_0014, 0, 0, 0, 0, 0);
        access(0, 0, 32'hFFFF_FC14, 0, 0, 0, 0, 0);
        access(0, 0, 32'h0000_0014, 0, 1, 0, 0, 0);
        // set 7: write-allocate miss, then read hit
        access(0, 1, 32'hFFFF_FC1C, 32'd99, 0, 0, 0, 0);
        access(0, 0, 32'hFFFF_FC1C, 0, 1, 0, 0, 0);
        // fill way1, then a third tag evicts the dirty way0
        access(0, 0, 32'h0000_003C, 0, 0, 0, 0, 0);
        access(0, 0, 32'h0000_001C, 0, 0, 1, 32'hFFFF_FC1C, 32'd99);
        // written-back word comes back from memory
        access(0, 0, 32'hFFFF_FC1C, 0, 0, 0, 0, 0);

        // stray memAck in IDLE
        @(negedge clk);
        mack[0] = 1'b1;
        @(negedge clk);
        mack[0] = 1'b0;
        chk("stray_ack_done", 32'(dn[0]), 0);
        chk("stray_ack_ready", 32'(rdy[0]), 1);
        chk("stray_ack_memReq", 32'(mrq[0]), 0);
        chk("stray_ack_miss", 32'(mcnt[0]), mc_m[0]);

        // direct-mapped build
        access(1, 0, 32'h0000_0014, 0, 0, 0, 0, 0);
        access(1, 0, 32'hFFFF_FC14, 0, 0, 0, 0, 0);
        access(1, 0, 32'h0000_0014, 0, 0, 0, 0, 0);
        access(1, 1, 32'h0000_0018, 32'h11, 0, 0, 0, 0);
        access(1, 0, 32'hFFFF_FC18, 0, 0, 1, 32'h0000_0018, 32'h11);

        // reset in the middle of a fill
        @(negedge clk);
        rd[0] = 1'b1;
        ad[0] = 32'h0000_0054;
        @(posedge clk);
        #1;
        rd[0] = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mrq[0]) seen = 1;
        end
        chk("rst_fill_req", 32'(seen), 1);
        rst_n = 0;
        #1;
        chk("rst2_memReq", 32'(mrq[0]), 0);
        chk("rst2_ready", 32'(rdy[0]), 1);
        chk("rst2_hitCount", 32'(hcnt[0]), 0);
        chk("rst2_missCount", 32'(mcnt[0]), 0);
        @(negedge clk);
        mack[0] = 1'b1;
        rst_n = 1;
        @(negedge clk);
        mack[0] = 1'b0;
        chk("rst2_ack_ignored_done", 32'(dn[0]), 0);
        chk("rst2_ack_ignored_req", 32'(mrq[0]), 0);
        for (int d = 0; d < 2; d++) begin
            hc_m[d] = 0;
            mc_m[d] = 0;
        end
        access(0, 0, 32'h0000_0014, 0, 0, 0, 0, 0);
        access(0, 0, 32'hFFFF_FC14, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
